// File: rtl/pnr_regbank_pkg.sv
// pnr_regbank_pkg: shared definitions for the PNR threshold register bank.
// Holds the bus register map offsets, the CTRL/STATUS bit positions,
// the ID magic byte and the commit state encoding.
package pnr_regbank_pkg;

    localparam logic [31:0] ADDR_LED    = 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0008;
    localparam logic [31:0] ADDR_ID     = 32'h0000_000C;
    localparam logic [31:0] ADDR_SHADOW = 32'h0000_0040;
    localparam logic [31:0] ADDR_ACTIVE = 32'h0000_0080;
    localparam logic [31:0] ADDR_CNT    = 32'h0000_0100;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_SYNC    = 1;
    localparam int CTRL_CNT_EN  = 2;
    localparam int CTRL_CNT_CLR = 3;

    localparam int STAT_PENDING  = 0;
    localparam int STAT_ORDER_OK = 1;
    localparam int STAT_REJECT   = 2;

    localparam logic [7:0] ID_MAGIC = 8'h50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } commit_state_e;

endpackage

// File: rtl/pnr_bin_counter.sv
// pnr_bin_counter: saturating event counter for one photon-number bin.
// Ports:
//   clk_i  - clock
//   rstn_i - synchronous active-low reset
//   en     - count one event this cycle
//   clr    - zero the counter (wins over en)
//   q      - current count, holds at all-ones
module pnr_bin_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pnr_regbank.sv
// pnr_regbank: system-bus register bank for the PNR discriminator.
// Keeps N_THR bus-writable shadow thresholds and an active set (thr_o) that
// is replaced atomically by a validated commit, either immediately or at the
// next frame strobe, plus one saturating event counter per photon-number bin.
// Ports:
//   clk_i, rstn_i              - clock, synchronous active-low reset
//   sys_addr/wdata/wen/ren     - bus request (only sys_addr[AW-1:0] decoded)
//   sys_rdata/err/ack          - registered bus response, one cycle after request
//   led_o                      - LED register
//   thr_o, thr_update_o        - active thresholds, one-cycle pulse on change
//   frame_i                    - frame-boundary strobe for synchronous commits
//   pnr_valid_i, pnr_bin_i     - discriminator result feeding the bin counters
module pnr_regbank
    import pnr_regbank_pkg::*;
#(
    parameter int N_THR = 7,
    parameter int ADC_W = 14,
    parameter int CNT_W = 32,
    parameter int AW    = 20
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [31:0]            sys_addr,
    input  logic [31:0]            sys_wdata,
    input  logic                   sys_wen,
    input  logic                   sys_ren,
    output logic [31:0]            sys_rdata,
    output logic                   sys_err,
    output logic                   sys_ack,
    output logic [7:0]             led_o,
    output logic [N_THR*ADC_W-1:0] thr_o,
    output logic                   thr_update_o,
    input  logic                   frame_i,
    input  logic                   pnr_valid_i,
    input  logic [3:0]             pnr_bin_i
);

    localparam int          TW     = N_THR * ADC_W;
    localparam logic [31:0] ID_VAL = {ID_MAGIC, 8'(N_THR), 8'(ADC_W), 8'(CNT_W)};

    logic [TW-1:0]    shadow;
    logic             sync_mode;
    logic             cnt_en;
    logic             commit_req;
    logic             pending;
    logic             reject;
    commit_state_e    state;

    logic [31:0]      addr;
    logic [31:0]      rd_val;
    logic             hit;
    logic             ro;
    logic             req;
    logic             dec_err;
    logic             wr_ok;
    logic             cnt_clr;
    logic             reject_clr;
    logic             active_ok;
    logic             unused_bits;

    logic [CNT_W-1:0] cnt_q [N_THR+1];
    logic [N_THR:0]   cnt_inc;

    // Threshold readback is sign-extended to the full bus width.
    function automatic logic [31:0] sext(input logic signed [ADC_W-1:0] v);
        return 32'(v);
    endfunction

    // True when the packed set is strictly increasing as signed values.
    function automatic logic is_increasing(input logic [TW-1:0] t);
        logic signed [ADC_W-1:0] lo;
        logic signed [ADC_W-1:0] hi;
        logic ok;
        ok = 1'b1;
        for (int k = 1; k < N_THR; k++) begin
            lo = t[(k-1)*ADC_W +: ADC_W];
            hi = t[k*ADC_W +: ADC_W];
            if (hi <= lo) ok = 1'b0;
        end
        return ok;
    endfunction

    assign addr        = 32'(sys_addr[AW-1:0]);
    assign unused_bits = ^{sys_addr, sys_wdata};
    assign active_ok   = is_increasing(thr_o);

    always_comb begin
        rd_val = '0;
        hit    = 1'b0;
        ro     = 1'b0;
        if (addr == ADDR_LED) begin
            hit    = 1'b1;
            rd_val = {24'd0, led_o};
        end
        if (addr == ADDR_CTRL) begin
            hit    = 1'b1;
            rd_val = {28'd0, 1'b0, cnt_en, sync_mode, 1'b0};
        end
        if (addr == ADDR_STATUS) begin
            hit    = 1'b1;
            rd_val = {29'd0, reject, active_ok, pending};
        end
        if (addr == ADDR_ID) begin
            hit    = 1'b1;
            ro     = 1'b1;
            rd_val = ID_VAL;
        end
        for (int k = 0; k < N_THR; k++) begin
            if (addr == ADDR_SHADOW + 32'(4 * k)) begin
                hit    = 1'b1;
                rd_val = sext(shadow[k*ADC_W +: ADC_W]);
            end
            if (addr == ADDR_ACTIVE + 32'(4 * k)) begin
                hit    = 1'b1;
                ro     = 1'b1;
                rd_val = sext(thr_o[k*ADC_W +: ADC_W]);
            end
        end
        for (int k = 0; k <= N_THR; k++) begin
            if (addr == ADDR_CNT + 32'(4 * k)) begin
                hit    = 1'b1;
                ro     = 1'b1;
                rd_val = 32'(cnt_q[k]);
            end
        end
    end

    assign req        = sys_wen | sys_ren;
    assign dec_err    = !hit || (sys_wen && ro);
    assign wr_ok      = sys_wen && !dec_err;
    assign cnt_clr    = wr_ok && (addr == ADDR_CTRL) && sys_wdata[CTRL_CNT_CLR];
    assign reject_clr = wr_ok && (addr == ADDR_STATUS) && sys_wdata[STAT_REJECT];

    // Bus response and writable register state; commit_req is a one-cycle
    // pulse so the commit machine acts on the CTRL value after the write.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sys_ack    <= 1'b0;
            sys_err    <= 1'b0;
            sys_rdata  <= '0;
            led_o      <= '0;
            sync_mode  <= 1'b0;
            cnt_en     <= 1'b0;
            commit_req <= 1'b0;
            shadow     <= '0;
        end else begin
            sys_ack    <= req;
            sys_err    <= req && dec_err;
            sys_rdata  <= (req && !dec_err) ? rd_val : '0;
            commit_req <= 1'b0;
            if (wr_ok) begin
                if (addr == ADDR_LED) led_o <= sys_wdata[7:0];
                if (addr == ADDR_CTRL) begin
                    sync_mode  <= sys_wdata[CTRL_SYNC];
                    cnt_en     <= sys_wdata[CTRL_CNT_EN];
                    commit_req <= sys_wdata[CTRL_COMMIT];
                end
                for (int k = 0; k < N_THR; k++) begin
                    if (addr == ADDR_SHADOW + 32'(4 * k))
                        shadow[k*ADC_W +: ADC_W] <= sys_wdata[ADC_W-1:0];
                end
            end
        end
    end

    // Commit machine: IDLE -> (ARMED ->) APPLY -> IDLE. ARMED only looks at
    // frame_i from the cycle after it was entered, so a strobe that lines up
    // with the COMMIT write cannot fire it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            reject       <= 1'b0;
            thr_o        <= '0;
            thr_update_o <= 1'b0;
        end else begin
            thr_update_o <= 1'b0;
            if (reject_clr) reject <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commit_req) begin
                        if (sync_mode) begin
                            state   <= ST_ARMED;
                            pending <= 1'b1;
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                end
                ST_ARMED: begin
                    if (frame_i) state <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (is_increasing(shadow)) begin
                        thr_o        <= shadow;
                        thr_update_o <= 1'b1;
                    end else begin
                        reject <= 1'b1;
                    end
                    pending <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b <= N_THR; b++) begin : g_bin
        assign cnt_inc[b] = cnt_en && pnr_valid_i && (pnr_bin_i == 4'(b));

        pnr_bin_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .en     (cnt_inc[b]),
            .clr    (cnt_clr),
            .q      (cnt_q[b])
        );
    end

endmodule

// File: tb/tb_pnr_regbank.sv
module tb_pnr_regbank;

    localparam int N_THR = 7;
    localparam int ADC_W = 14;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [31:0]            sys_addr;
    logic [31:0]            sys_wdata;
    logic                   sys_wen;
    logic                   sys_ren;
    logic [31:0]            sys_rdata, sys_rdata2;
    logic                   sys_err, sys_err2;
    logic                   sys_ack, sys_ack2;
    logic [7:0]             led, led2;
    logic [N_THR*ADC_W-1:0] thr, thr2;
    logic                   upd, upd2;
    logic                   frame;
    logic                   valid, valid2;
    logic [3:0]             bin;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd, rd2;
    logic        e;

    always #5 clk = ~clk;

    pnr_regbank #(.N_THR(N_THR), .ADC_W(ADC_W), .CNT_W(32), .AW(20)) dut (
        .clk_i(clk), .rstn_i(rstn), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err),
        .sys_ack(sys_ack), .led_o(led), .thr_o(thr), .thr_update_o(upd),
        .frame_i(frame), .pnr_valid_i(valid), .pnr_bin_i(bin)
    );

    // Narrow-counter instance for saturation; shares the bus with dut.
    pnr_regbank #(.N_THR(N_THR), .ADC_W(ADC_W), .CNT_W(3), .AW(20)) dut2 (
        .clk_i(clk), .rstn_i(rstn), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata2), .sys_err(sys_err2),
        .sys_ack(sys_ack2), .led_o(led2), .thr_o(thr2), .thr_update_o(upd2),
        .frame_i(frame), .pnr_valid_i(valid2), .pnr_bin_i(bin)
    );

    function automatic logic [31:0] thr_k(input int k);
        return 32'(thr[k*ADC_W +: ADC_W]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic err_o);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        chk("wr_ack", {31'd0, sys_ack}, 32'd1);
        err_o = sys_err;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d2,
                          output logic err_o);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        chk("rd_ack", {31'd0, sys_ack}, 32'd1);
        d = sys_rdata; d2 = sys_rdata2; err_o = sys_err;
    endtask

    initial begin
        rstn = 1'b0; sys_addr = '0; sys_wdata = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        frame = 1'b0; valid = 1'b0; valid2 = 1'b0; bin = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, sys_ack}, 32'd0);
        chk("rst_err", {31'd0, sys_err}, 32'd0);
        chk("rst_rdata", sys_rdata, 32'd0);
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_thr_lo", thr[31:0], 32'd0);
        chk("rst_upd", {31'd0, upd}, 32'd0);
        rstn = 1'b1;

        bus_rd(32'h00C, rd, rd2, e);
        chk("id", rd, 32'h5007_0E20);
        chk("id_err", {31'd0, e}, 32'd0);
        bus_rd(32'h080, rd, rd2, e);
        chk("active0_rst", rd, 32'd0);
        bus_rd(32'h008, rd, rd2, e);
        chk("status_rst", rd, 32'd0);
        chk("upd_idle", {31'd0, upd}, 32'd0);

        bus_wr(32'h000, 32'hFFFF_FFA5, e);
        chk("led_o", {24'd0, led}, 32'h0000_00A5);
        bus_rd(32'h000, rd, rd2, e);
        chk("led_rd", rd, 32'h0000_00A5);

        // Immediate commit of 100..700
        for (int k = 0; k < N_THR; k++) bus_wr(32'h040 + 32'(4 * k), 32'(100 * (k + 1)), e);
        bus_wr(32'h004, 32'h1, e);
        chk("commit_upd_ack", {31'd0, upd}, 32'd0);
        @(negedge clk);
        chk("commit_upd_c1", {31'd0, upd}, 32'd0);
        @(negedge clk);
        chk("commit_upd_c2", {31'd0, upd}, 32'd1);
        chk("commit_thr6", thr_k(6), 32'd700);
        @(negedge clk);
        chk("commit_upd_c3", {31'd0, upd}, 32'd0);
        bus_rd(32'h098, rd, rd2, e);
        chk("active6_rd", rd, 32'd700);
        bus_rd(32'h008, rd, rd2, e);
        chk("status_ok", rd, 32'h2);
        bus_rd(32'h004, rd, rd2, e);
        chk("ctrl_commit_reads0", rd, 32'h0);

        // Non-monotonic commit is rejected
        bus_wr(32'h048, 32'hFFFF_FFFB, e);
        bus_rd(32'h048, rd, rd2, e);
        chk("shadow2_sext", rd, 32'hFFFF_FFFB);
        bus_wr(32'h004, 32'h1, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reject_no_upd", {31'd0, upd}, 32'd0);
        end
        chk("reject_thr2", thr_k(2), 32'd300);
        bus_rd(32'h008, rd, rd2, e);
        chk("status_reject", rd, 32'h6);
        bus_wr(32'h008, 32'h4, e);
        chk("status_w1c_err", {31'd0, e}, 32'd0);
        bus_rd(32'h008, rd, rd2, e);
        chk("status_w1c", rd, 32'h2);
        bus_wr(32'h048, 32'd300, e);

        // Frame-synchronous commit; strobe coincident with the write is ignored
        bus_wr(32'h004, 32'h2, e);
        @(negedge clk);
        sys_addr = 32'h004; sys_wdata = 32'h3; sys_wen = 1'b1; frame = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0; frame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("armed_no_upd", {31'd0, upd}, 32'd0);
        end
        bus_rd(32'h008, rd, rd2, e);
        chk("status_pending", rd, 32'h3);
        bus_wr(32'h040, 32'd50, e);
        chk("armed_thr0_held", thr_k(0), 32'd100);
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        chk("frame_upd_c0", {31'd0, upd}, 32'd0);
        @(negedge clk);
        chk("frame_upd_c1", {31'd0, upd}, 32'd1);
        chk("frame_thr0", thr_k(0), 32'd50);
        @(negedge clk);
        chk("frame_upd_c2", {31'd0, upd}, 32'd0);
        bus_rd(32'h008, rd, rd2, e);
        chk("status_after_frame", rd, 32'h2);

        // Counters
        bus_wr(32'h004, 32'h4, e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); valid = 1'b1; bin = 4'd3;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); valid = 1'b1; bin = 4'd9;
        end
        @(negedge clk); valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); valid2 = 1'b1; bin = 4'd3;
        end
        @(negedge clk); valid2 = 1'b0;
        bus_rd(32'h10C, rd, rd2, e);
        chk("cnt3", rd, 32'd5);
        chk("cnt3_sat", rd2, 32'd7);
        bus_rd(32'h100, rd, rd2, e);
        chk("cnt0", rd, 32'd0);
        bus_rd(32'h11C, rd, rd2, e);
        chk("cnt7", rd, 32'd0);
        bus_rd(32'h124, rd, rd2, e);
        chk("cnt9_unmapped", {31'd0, e}, 32'd1);

        @(negedge clk);
        sys_addr = 32'h004; sys_wdata = 32'hC; sys_wen = 1'b1;
        valid = 1'b1; valid2 = 1'b1; bin = 4'd3;
        @(negedge clk);
        sys_wen = 1'b0; valid = 1'b0; valid2 = 1'b0;
        bus_rd(32'h10C, rd, rd2, e);
        chk("cnt_clr", rd, 32'd0);
        chk("cnt_clr_sat", rd2, 32'd0);

        // Errors
        bus_rd(32'h200, rd, rd2, e);
        chk("unmapped_err", {31'd0, e}, 32'd1);
        chk("unmapped_rdata", rd, 32'd0);
        bus_wr(32'h080, 32'd123, e);
        chk("ro_wr_err", {31'd0, e}, 32'd1);
        bus_rd(32'h080, rd, rd2, e);
        chk("ro_wr_nochange", rd, 32'd50);
        bus_wr(32'h00C, 32'd0, e);
        chk("id_wr_err", {31'd0, e}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pnr_regbank.md
Name: pnr_regbank

Overview:
- Parametrised successor of the photon-number-resolving threshold register block; sits on the Red Pitaya system bus between the PS and the PNR discriminator.
- Holds N_THR bus-writable shadow thresholds and an active set driven to the discriminator. The active set updates atomically on a validated commit, either immediately or at the next frame boundary.
- Keeps saturating per-bin photon-number event counters, readable over the bus.

Parameters:
N_THR, 7, number of thresholds (1..15); bins = N_THR+1
ADC_W, 14, threshold width, two's-complement signed
CNT_W, 32, bin counter width (1..32)
AW, 20, number of decoded sys_addr bits

Ports:
clk_i  in  1  processing clock
rstn_i  in  1  reset; synchronous, active-low
sys_addr  in  32  bus address; only [AW-1:0] decoded
sys_wdata  in  32  bus write data
sys_wen  in  1  bus write enable
sys_ren  in  1  bus read enable
sys_rdata  out  32  bus read data
sys_err  out  1  bus error
sys_ack  out  1  bus acknowledge
led_o  out  8  LED register
thr_o  out  N_THR*ADC_W  active thresholds; threshold k occupies [k*ADC_W +: ADC_W]
thr_update_o  out  1  one-cycle pulse when the active set changes
frame_i  in  1  frame-boundary strobe
pnr_valid_i  in  1  discriminator result valid
pnr_bin_i  in  4  photon-number bin, 0..N_THR

Behaviour:
- Reset (rstn_i low at clk_i edge) clears to zero: led_o, shadow thresholds, thr_o, all counters, CTRL, STATUS, the pending flag, sys_ack, sys_err, sys_rdata and thr_update_o. Reset mid-commit or while pending drops the commit.
- Bus timing: sys_ack is registered one cycle after any sys_wen|sys_ren; sys_rdata is valid in the same cycle as sys_ack. Write side effects are visible from the following edge.
- Unmapped addresses and writes to read-only registers: sys_ack=1 and sys_err=1 in the ack cycle, rdata=0, no state change.
- Write data is taken from the low bits; wider fields are ignored. Readback of thresholds is sign-extended to 32 bits.
- Address map (byte offsets):
  - 0x000 LED (RW, 8b)
  - 0x004 CTRL (RW). bit0 COMMIT (write-1, self-clears, reads 0). bit1 SYNC_MODE. bit2 CNT_EN. bit3 CNT_CLR (write-1, self-clears, reads 0).
  - 0x008 STATUS (RO, except bit2 which is W1C). bit0 PENDING. bit1 ACTIVE_ORDER_OK. bit2 REJECT (sticky).
  - 0x00C ID (RO) = {8'h50, 8'(N_THR), 8'(ADC_W), 8'(CNT_W)}
  - 0x040+4k shadow threshold k (RW), k < N_THR
  - 0x080+4k active threshold k (RO)
  - 0x100+4k bin counter k (RO), k <= N_THR
- Commit validation: the shadow set must be strictly increasing as signed values (t0<t1<...). The check is on the shadow state at the commit-execution cycle.
  - Pass: thr_o <= shadow, thr_update_o=1 for that one cycle, PENDING=0.
  - Fail: thr_o unchanged, REJECT=1, PENDING=0.
- Commit state machine, states IDLE, ARMED, APPLY:
  - IDLE -> APPLY on COMMIT write with SYNC_MODE=0 (SYNC_MODE sampled from CTRL after that write).
  - IDLE -> ARMED on COMMIT write with SYNC_MODE=1; PENDING=1.
  - ARMED -> APPLY on the first frame_i high strictly after the arming cycle. A frame_i coinciding with the COMMIT write does not fire.
  - APPLY -> IDLE after one cycle, doing the validate/transfer.
  - Shadow writes while ARMED are allowed; the values present at APPLY are used.
  - COMMIT while ARMED or APPLY is ignored (no error).
  - Clearing SYNC_MODE while ARMED: stay ARMED until frame_i.
- ACTIVE_ORDER_OK is combinational from thr_o, so it reads 0 after reset when all thresholds are zero and N_THR>1.
- Counters:
  - When CNT_EN=1, pnr_valid_i=1 and pnr_bin_i<=N_THR, counter[pnr_bin_i] increments by 1, saturating at 2^CNT_W-1.
  - Out-of-range bins are ignored.
  - CNT_CLR zeroes all counters that cycle; clear has priority over a same-cycle increment.
  - A read returns the pre-edge value.

Decomposition:
- Package pnr_regbank_pkg: address offsets, CTRL/STATUS bit indices, ID magic 8'h50, commit-state enum.
- Sub-module pnr_bin_counter (CNT_W): saturating counter with en, clr and q; instantiated N_THR+1 times via generate.

Test Plan:
- Reset then read ID with N_THR=7 -> 0x50070E20. Read 0x080 -> 0. thr_update_o stays 0.
- Write shadows 100,200,...,700, then CTRL=0x1 -> thr_update_o pulses exactly 1 cycle, 2 cycles after the ack. 0x098 reads 700. PENDING=0, REJECT=0.
- Shadow t2=-5 (non-monotonic), commit -> thr_o unchanged, REJECT=1. Write STATUS bit2=1 -> REJECT=0.
- CTRL=0x2 then 0x3 -> PENDING=1 and thr_o held. Change shadow t0 to 50, then frame_i pulse -> thr_o t0=50 and a one-cycle pulse. A frame_i in the same cycle as the COMMIT write does not apply.
- CNT_EN=1, 5 pulses on bin 3, 2 on bin 9 (invalid) -> counter3=5, others 0. With CNT_W=3 and 10 pulses -> 7. CNT_CLR together with pnr_valid_i -> 0.
- Read 0x200 -> sys_err=1, rdata=0. Write 0x080 -> sys_err=1, active unchanged.
